// File: rtl/moveobj_bbox_detect.sv
// Per-frame bounding box of the cleaned motion mask: counts foreground pixels and tracks
// min/max column/row, publishing a box (and a one-cycle frame_done) on each vsync rise.
module moveobj_bbox_detect #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int MIN_PIXELS = 64,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int CNT_W      = 20
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             pre_vsync,
  input  logic             pre_href,
  input  logic             pre_wr_en,
  input  logic             pre_1bit,
  output logic             box_valid,
  output logic [X_W-1:0]   box_x_min,
  output logic [X_W-1:0]   box_x_max,
  output logic [Y_W-1:0]   box_y_min,
  output logic [Y_W-1:0]   box_y_max,
  output logic [CNT_W-1:0] box_pix_cnt,
  output logic             frame_done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, PUBLISH} state_t;

  typedef struct packed {
    logic [X_W-1:0]   x_min;
    logic [X_W-1:0]   x_max;
    logic [Y_W-1:0]   y_min;
    logic [Y_W-1:0]   y_max;
    logic [CNT_W-1:0] cnt;
  } acc_t;

  localparam acc_t ACC_INIT = '{
    x_min: X_W'(IMG_W - 1),
    x_max: '0,
    y_min: Y_W'(IMG_H - 1),
    y_max: '0,
    cnt:   '0
  };

  state_t state_q, state_d;
  logic   vs_d, hs_d;
  logic   vs_rise, hs_fall;
  logic   pix_ok, fg_hit, pub;
  logic   line_hit;
  logic [X_W-1:0] col;
  logic [Y_W-1:0] row;
  acc_t   acc;

  assign vs_rise = pre_vsync & ~vs_d;
  assign hs_fall = ~pre_href & hs_d;
  assign pix_ok  = pre_wr_en & pre_href & ~pre_vsync
                 & (col < X_W'(IMG_W)) & (row < Y_W'(IMG_H));
  assign fg_hit  = pix_ok & pre_1bit & (state_q != IDLE);
  assign pub     = (state_q == ACTIVE) & vs_rise;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= 1'b0;
      hs_d <= 1'b0;
    end else begin
      vs_d <= pre_vsync;
      hs_d <= pre_href;
    end
  end

  // col saturates at IMG_W because pix_ok stops accepting there; same holds for row.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      line_hit <= 1'b0;
    end else begin
      if (vs_rise || hs_fall) col <= '0;
      else if (pix_ok)        col <= col + 1'b1;

      if (vs_rise)                  row <= '0;
      else if (hs_fall && line_hit) row <= row + 1'b1;

      if (vs_rise || hs_fall) line_hit <= 1'b0;
      else if (pix_ok)        line_hit <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vs_rise) state_d = ACTIVE;
      ACTIVE:  if (vs_rise) state_d = PUBLISH;
      PUBLISH: state_d = ACTIVE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulators restart on the publishing edge so the PUBLISH cycle already belongs
  // to the new frame; IDLE holds them at init so a partial frame never leaks through.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= ACC_INIT;
    end else if (state_q == IDLE || pub) begin
      acc <= ACC_INIT;
    end else if (fg_hit) begin
      if (acc.cnt != {CNT_W{1'b1}}) acc.cnt <= acc.cnt + 1'b1;
      if (col < acc.x_min) acc.x_min <= col;
      if (col > acc.x_max) acc.x_max <= col;
      if (row < acc.y_min) acc.y_min <= row;
      if (row > acc.y_max) acc.y_max <= row;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      box_valid   <= 1'b0;
      box_x_min   <= '0;
      box_x_max   <= '0;
      box_y_min   <= '0;
      box_y_max   <= '0;
      box_pix_cnt <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= pub;
      if (pub) begin
        box_pix_cnt <= acc.cnt;
        if (acc.cnt >= CNT_W'(MIN_PIXELS)) begin
          box_valid <= 1'b1;
          box_x_min <= acc.x_min;
          box_x_max <= acc.x_max;
          box_y_min <= acc.y_min;
          box_y_max <= acc.y_max;
        end else begin
          box_valid <= 1'b0;
          box_x_min <= '0;
          box_x_max <= '0;
          box_y_min <= '0;
          box_y_max <= '0;
        end
      end
    end
  end

endmodule
